// File: rtl/cycle_sequencer.sv
// cycle_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control with wait-states, run/step, halt and fault.
module cycle_sequencer #(
   parameter int MEM_WAIT_MAX = 15,
   parameter int CNT_W        = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             run,
   input  logic             step,
   input  logic [3:0]       opcode,
   input  logic             mem_ready,
   output logic [2:0]       state,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic             ir_we,
   output logic             pc_we,
   output logic             alu_en,
   output logic             reg_we,
   output logic             busy,
   output logic [CNT_W-1:0] cycle_count
);
   localparam int WW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED, S_FAULT
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic [WW-1:0]    wait_q, wait_d;
   logic             one_q, one_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout;
   state_t           eoi;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         wait_q  <= '0;
         one_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         wait_q  <= wait_d;
         one_q   <= one_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      wait_d  = wait_q;
      one_d   = one_q;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      alu_en  = 1'b0;
      reg_we  = 1'b0;
      timeout = (wait_q == WW'(MEM_WAIT_MAX)) && !mem_ready;
      eoi     = (run && !one_q) ? S_FETCH : S_IDLE;
      case (state_q)
         S_IDLE: begin
            state_d = (run || step) ? S_FETCH : S_IDLE;
            one_d   = !run && step;
         end
         S_FETCH: begin
            mem_rd  = !timeout;
            ir_we   = mem_ready;
            pc_we   = mem_ready;
            state_d = mem_ready ? S_DECODE : timeout ? S_FAULT : S_FETCH;
            wait_d  = mem_ready ? '0 : wait_q + 1'b1;
         end
         S_DECODE: begin
            op_d    = opcode;
            state_d = (opcode == 4'h0) ? eoi :
                      (opcode == 4'hF) ? S_HALTED :
                      (opcode >= 4'hB) ? S_FAULT : S_EXEC;
         end
         S_EXEC: begin
            alu_en  = 1'b1;
            pc_we   = (op_q == 4'hA);
            state_d = (op_q == 4'hA) ? eoi : op_q[3] ? S_MEM : S_WB;
         end
         S_MEM: begin
            mem_rd  = !timeout && (op_q == 4'h8);
            mem_wr  = !timeout && (op_q == 4'h9);
            state_d = mem_ready ? ((op_q == 4'h8) ? S_WB : eoi) : timeout ? S_FAULT : S_MEM;
            wait_d  = mem_ready ? '0 : wait_q + 1'b1;
         end
         S_WB: begin
            reg_we  = 1'b1;
            state_d = eoi;
         end
         default: state_d = state_q;
      endcase
      if (state_q != S_IDLE && state_d == S_IDLE) one_d = 1'b0;
      cnt_d = (busy && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   end

   assign state       = state_q;
   assign busy        = !(state_q == S_IDLE || state_q == S_HALTED || state_q == S_FAULT);
   assign cycle_count = cnt_q;
endmodule

// File: tb/tb_cycle_sequencer.sv
// tb_cycle_sequencer: scoreboard bench replaying per-cycle expected state/strobe vectors.
module tb_cycle_sequencer;
   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        run = 1'b0;
   logic        step = 1'b0;
   logic [3:0]  opcode = 4'h0;
   logic        mem_ready = 1'b0;
   logic [2:0]  state;
   logic        mem_rd, mem_wr, ir_we, pc_we, alu_en, reg_we, busy;
   logic [15:0] cycle_count;

   int n_chk = 0;
   int n_err = 0;

   logic [9:0] exp_q[$];
   logic       mr_q[$];
   logic       st_q[$];

   cycle_sequencer #(.MEM_WAIT_MAX(15), .CNT_W(16)) dut (
      .clock(clock), .reset_n(reset_n), .run(run), .step(step), .opcode(opcode),
      .mem_ready(mem_ready), .state(state), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .ir_we(ir_we), .pc_we(pc_we), .alu_en(alu_en), .reg_we(reg_we), .busy(busy),
      .cycle_count(cycle_count)
   );

   always #50 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // sb = {mem_rd, mem_wr, ir_we, pc_we, alu_en, reg_we}
   task automatic push(input logic mr, input logic stp, input logic [2:0] st, input logic [5:0] sb);
      mr_q.push_back(mr);
      st_q.push_back(stp);
      exp_q.push_back({st, sb, !(st == 3'd0 || st == 3'd6 || st == 3'd7)});
   endtask

   task automatic replay(input string tag);
      while (exp_q.size() > 0) begin
         @(negedge clock);
         mem_ready = mr_q.pop_front();
         step = st_q.pop_front();
         #1;
         chk(tag, {22'd0, state, mem_rd, mem_wr, ir_we, pc_we, alu_en, reg_we, busy}, {22'd0, exp_q.pop_front()});
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      chk("rst_state", {29'd0, state}, 32'd0);
      chk("rst_count", {16'd0, cycle_count}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      #20;
      chk("por_state", {29'd0, state}, 32'd0);
      chk("por_strb", {26'd0, mem_rd, mem_wr, ir_we, pc_we, alu_en, reg_we}, 32'd0);
      do_reset();
      opcode = 4'h3;
      run = 1'b1;
      push(1, 0, 3'd1, 6'b101100);
      push(1, 0, 3'd2, 6'b000000);
      push(1, 0, 3'd3, 6'b000010);
      push(1, 0, 3'd5, 6'b000001);
      push(1, 0, 3'd1, 6'b101100);
      replay("alu_run");
      chk("alu_count", {16'd0, cycle_count}, 32'd4);
      run = 1'b0;
      push(1, 0, 3'd2, 6'b000000);
      push(1, 0, 3'd3, 6'b000010);
      push(1, 0, 3'd5, 6'b000001);
      push(1, 0, 3'd0, 6'b000000);
      replay("alu_stop");
      chk("alu_count2", {16'd0, cycle_count}, 32'd8);

      do_reset();
      opcode = 4'h8;
      push(0, 1, 3'd0, 6'b000000);
      for (int i = 0; i < 3; i++) push(0, 0, 3'd1, 6'b100000);
      push(1, 0, 3'd1, 6'b101100);
      push(0, 0, 3'd2, 6'b000000);
      push(0, 0, 3'd3, 6'b000010);
      push(0, 0, 3'd4, 6'b100000);
      push(0, 0, 3'd4, 6'b100000);
      push(1, 0, 3'd4, 6'b100000);
      push(0, 0, 3'd5, 6'b000001);
      push(0, 0, 3'd0, 6'b000000);
      replay("load_wait");
      chk("load_count", {16'd0, cycle_count}, 32'd10);

      opcode = 4'h9;
      push(1, 1, 3'd0, 6'b000000);
      push(1, 0, 3'd1, 6'b101100);
      push(1, 1, 3'd2, 6'b000000);
      push(1, 0, 3'd3, 6'b000010);
      push(1, 0, 3'd4, 6'b010000);
      push(1, 0, 3'd0, 6'b000000);
      push(1, 0, 3'd0, 6'b000000);
      replay("store_step");

      do_reset();
      run = 1'b1;
      for (int i = 0; i < 15; i++) push(0, 0, 3'd1, 6'b100000);
      push(0, 0, 3'd1, 6'b000000);
      for (int i = 0; i < 3; i++) push(1, 0, 3'd7, 6'b000000);
      replay("timeout");
      run = 1'b0;
      do_reset();

      opcode = 4'hF;
      run = 1'b1;
      push(1, 0, 3'd1, 6'b101100);
      push(1, 0, 3'd2, 6'b000000);
      push(1, 0, 3'd6, 6'b000000);
      push(1, 1, 3'd6, 6'b000000);
      replay("halt");
      chk("halt_count", {16'd0, cycle_count}, 32'd2);
      do_reset();
      opcode = 4'hC;
      push(1, 0, 3'd1, 6'b101100);
      push(1, 0, 3'd2, 6'b000000);
      push(1, 0, 3'd7, 6'b000000);
      push(1, 0, 3'd7, 6'b000000);
      replay("illegal");

      do_reset();
      opcode = 4'h3;
      push(1, 0, 3'd1, 6'b101100);
      push(1, 0, 3'd2, 6'b000000);
      push(1, 0, 3'd3, 6'b000010);
      push(1, 0, 3'd5, 6'b000001);
      replay("pre_rst");
      #10;
      reset_n = 1'b0;
      #1;
      chk("async_state", {29'd0, state}, 32'd0);
      chk("async_reg_we", {31'd0, reg_we}, 32'd0);
      chk("async_count", {16'd0, cycle_count}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      push(1, 0, 3'd1, 6'b101100);
      push(1, 0, 3'd2, 6'b000000);
      replay("restart");
      chk("restart_count", {16'd0, cycle_count}, 32'd1);
      run = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/cycle_sequencer.md
Name: cycle_sequencer

Overview:
- Multi-cycle control sequencer for the RISC CPU. It consumes the free-running `clock` from the clock generator and splits it into instruction phases: FETCH, DECODE, EXEC, MEM and WB.
- It issues the per-phase write and memory strobes to the datapath.
- It handles memory wait-states, run/single-step control, halt and illegal-opcode fault.

Parameters:
- MEM_WAIT_MAX, 15: maximum consecutive cycles a memory phase may wait for mem_ready; exceeding it enters FAULT.
- CNT_W, 16: width of cycle_count.

Ports:
- clock  in  1  system clock, rising-edge active.
- reset_n  in  1  asynchronous active-low reset.
- run  in  1  level; continuous execution while high.
- step  in  1  single-cycle pulse; executes exactly one instruction from IDLE.
- opcode  in  4  IR opcode field; valid from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- state  out  3  current state: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALTED=6, FAULT=7.
- mem_rd  out  1  memory read request.
- mem_wr  out  1  memory write request.
- ir_we  out  1  IR write strobe.
- pc_we  out  1  PC write strobe.
- alu_en  out  1  ALU operation enable.
- reg_we  out  1  register-file write strobe.
- busy  out  1  high when state is not IDLE, HALTED or FAULT.
- cycle_count  out  CNT_W  busy cycles since reset, saturating.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; all strobes 0; cycle_count=0; wait counter=0; latched opcode=0.
  - Takes effect immediately, mid-instruction included; no partial strobe survives.
- State, latched opcode, wait counter and cycle_count are registered. All strobes are combinational from the current state, the latched opcode and mem_ready.
- Opcode classes, with the states each class visits:
  - 0 NOP: F D.
  - 1-7 ALU: F D E W.
  - 8 LOAD: F D E M W.
  - 9 STORE: F D E M.
  - A BRANCH: F D E.
  - F HALT: F D then HALTED.
  - B-E illegal: F D then FAULT.
- IDLE:
  - run=1 -> FETCH.
  - Otherwise step=1 -> FETCH with the one-shot flag set.
  - If run and step are both 1, run wins and the one-shot flag stays clear.
- FETCH:
  - mem_rd=1.
  - While mem_ready=0: stay and increment the wait counter.
  - In the mem_ready=1 cycle: ir_we=1, pc_we=1, next state DECODE, wait counter cleared.
- DECODE:
  - Latch opcode into op_q; no strobes.
  - Next state by opcode class: NOP -> end-of-instruction; HALT -> HALTED; illegal -> FAULT; all others -> EXEC.
- EXEC:
  - alu_en=1 for one cycle; pc_we=1 additionally for BRANCH.
  - Next state: ALU -> WB; LOAD/STORE -> MEM; BRANCH -> end-of-instruction.
- MEM:
  - mem_rd=1 for LOAD, mem_wr=1 for STORE.
  - Waits like FETCH.
  - On mem_ready: LOAD -> WB; STORE -> end-of-instruction.
- WB: reg_we=1 for one cycle, then end-of-instruction.
- End-of-instruction (transition taken from the last state):
  - run=1 and one-shot flag clear -> FETCH.
  - Otherwise -> IDLE, clearing the one-shot flag.
  - run is sampled at that edge only; step is ignored while busy.
- Wait timeout: if the wait counter reaches MEM_WAIT_MAX while mem_ready=0, next state is FAULT and all strobes drop. mem_ready arriving in the same cycle as the count reaching MEM_WAIT_MAX counts as success.
- HALTED and FAULT are sticky and exit only via reset. All strobes are 0 in both.
- cycle_count:
  - Increments on every clock edge where busy=1.
  - Saturates at all-ones; no wrap.
- Strobe guarantee: mem_rd and mem_wr are never both 1; ir_we is only ever 1 in FETCH.

Test Plan:
- ALU op 3, run=1, mem_ready tied 1 (100 ns clock) -> state sequence 1,2,3,5,1; ir_we+pc_we high in FETCH, alu_en in EXEC, reg_we in WB; cycle_count=4 after one instruction.
- LOAD, mem_ready delayed 3 cycles in FETCH and 2 in MEM -> FETCH held 4 cycles, MEM held 3 cycles; mem_rd high throughout both; reg_we pulses once in WB; total 10 busy cycles.
- step pulse with run=0, STORE op -> states 1,2,3,4 then 0; mem_wr high only in MEM; a second step pulse issued mid-instruction is ignored.
- mem_ready held 0 in FETCH, MEM_WAIT_MAX=15 -> FAULT (7) entered on the 16th FETCH cycle; state remains 7 with run=1 until reset_n=0, then 0.
- HALT opcode F, then illegal opcode C (after reset) -> state 6 with strobes 0; after reset plus opcode C -> state 7 directly after DECODE.
- reset_n pulled low mid-WB, asynchronously between edges -> reg_we and state return to 0 immediately; cycle_count=0; execution restarts from FETCH on the first edge after release with run=1.
